// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, two-word instruction assembly, stall/redirect
// handling and the IF/ID pipeline register.
// Optional feature macro: FETCH_PERF_CNT_EN adds issued_cnt / bubble_cnt.
module fetch_stage #(
    parameter int unsigned ADDR_W       = 20,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [15:0] NOP_WORD     = 16'hF800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic [15:0]       ifid_inst,
    output logic [15:0]       ifid_imm,
    output logic [ADDR_W-1:0] ifid_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       issued_cnt,
    output logic [31:0]       bubble_cnt,
`endif
    output logic              ifid_valid
);

    localparam int unsigned OPC_W = 5;

    typedef enum logic {
        FETCH_OP  = 1'b0,
        FETCH_IMM = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       hold_op;
    logic [ADDR_W-1:0] hold_pc;
    logic              two_word_c;

    // ldm, shl and shr carry a trailing 16-bit immediate word
    always_comb begin
        two_word_c = 1'b0;
        case (imem_data[15:11])
            OPC_W'(5'b00111),
            OPC_W'(5'b10100),
            OPC_W'(5'b10101): two_word_c = 1'b1;
            default:          two_word_c = 1'b0;
        endcase
    end

    assign imem_addr = pc;

    // PC, assembly state and IF/ID register; priority rst > redirect > stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_VECTOR;
            state      <= FETCH_OP;
            hold_op    <= '0;
            hold_pc    <= '0;
            ifid_inst  <= NOP_WORD;
            ifid_imm   <= '0;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
        end else if (redirect) begin
            pc         <= redirect_pc;
            state      <= FETCH_OP;
            hold_op    <= '0;
            hold_pc    <= '0;
            ifid_inst  <= NOP_WORD;
            ifid_imm   <= '0;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            pc <= pc + ADDR_W'(1);
            case (state)
                FETCH_OP: begin
                    if (two_word_c) begin
                        hold_op    <= imem_data;
                        hold_pc    <= pc;
                        state      <= FETCH_IMM;
                        ifid_inst  <= NOP_WORD;
                        ifid_imm   <= '0;
                        ifid_pc    <= '0;
                        ifid_valid <= 1'b0;
                    end else begin
                        ifid_inst  <= imem_data;
                        ifid_imm   <= '0;
                        ifid_pc    <= pc;
                        ifid_valid <= 1'b1;
                    end
                end
                FETCH_IMM: begin
                    ifid_inst  <= hold_op;
                    ifid_imm   <= imem_data;
                    ifid_pc    <= hold_pc;
                    ifid_valid <= 1'b1;
                    state      <= FETCH_OP;
                end
                default: state <= FETCH_OP;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic load_valid_c;

    // IF/ID receives a real instruction this cycle (when it updates at all)
    always_comb begin
        load_valid_c = 1'b0;
        if (!redirect)
            load_valid_c = (state == FETCH_IMM) || !two_word_c;
    end

    // Issue/bubble counters advance only when IF/ID actually updates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_cnt <= '0;
            bubble_cnt <= '0;
        end else if (redirect || !stall) begin
            if (load_valid_c)
                issued_cnt <= issued_cnt + 32'd1;
            else
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;

    localparam int unsigned ADDR_W = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_data;
    logic [15:0]       ifid_inst;
    logic [15:0]       ifid_imm;
    logic [ADDR_W-1:0] ifid_pc;
    logic              ifid_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       issued_cnt;
    logic [31:0]       bubble_cnt;
`endif

    logic [15:0] mem [0:63];
    logic [15:0] top_word;
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // Instruction memory: low 64 words, the all-ones word, NOP elsewhere
    assign imem_data = (imem_addr < 20'd64) ? mem[imem_addr[5:0]] :
                       ((imem_addr == 20'hFFFFF) ? top_word : 16'hF800);

    fetch_stage #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
        .ifid_inst(ifid_inst), .ifid_imm(ifid_imm), .ifid_pc(ifid_pc),
`ifdef FETCH_PERF_CNT_EN
        .issued_cnt(issued_cnt), .bubble_cnt(bubble_cnt),
`endif
        .ifid_valid(ifid_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 16'hF800;
        top_word = 16'hF800;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_if(input string tag, input logic [15:0] inst, input logic [15:0] imm,
                          input logic [ADDR_W-1:0] pc, input logic valid);
        chk({tag, ".inst"},  32'(ifid_inst),  32'(inst));
        chk({tag, ".imm"},   32'(ifid_imm),   32'(imm));
        chk({tag, ".pc"},    32'(ifid_pc),    32'(pc));
        chk({tag, ".valid"}, 32'(ifid_valid), 32'(valid));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        clear_mem();

        // Reset values and single-word free run
        mem[0] = 16'h2800; mem[1] = 16'h1000; mem[2] = 16'h8800;
        tick();
        chk_if("rst", 16'hF800, 16'h0000, 20'h0, 1'b0);
        chk("rst.addr", 32'(imem_addr), 32'h0);
        rst = 1'b0;
        tick(); chk_if("run1", 16'h2800, 16'h0, 20'h0, 1'b1);
        tick(); chk_if("run2", 16'h1000, 16'h0, 20'h1, 1'b1);
        tick(); chk_if("run3", 16'h8800, 16'h0, 20'h2, 1'b1);

        // Two-word ldm
        clear_mem();
        mem[0] = 16'h3800; mem[1] = 16'h00AB; mem[2] = 16'hF800;
        do_reset();
        tick(); chk_if("tw1", 16'hF800, 16'h0, 20'h0, 1'b0);
        tick(); chk_if("tw2", 16'h3800, 16'h00AB, 20'h0, 1'b1);
        tick(); chk_if("tw3", 16'hF800, 16'h0, 20'h2, 1'b1);

        // Stall freezes stage for three cycles
        clear_mem();
        for (int i = 0; i < 6; i++) mem[i] = 16'h1001 + 16'(i);
        do_reset();
        tick(); chk_if("st0", 16'h1001, 16'h0, 20'h0, 1'b1);
        tick(); chk_if("st1", 16'h1002, 16'h0, 20'h1, 1'b1);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_if("stall", 16'h1002, 16'h0, 20'h1, 1'b1);
            chk("stall.addr", 32'(imem_addr), 32'h2);
        end
        stall = 1'b0;
        tick(); chk_if("st2", 16'h1003, 16'h0, 20'h2, 1'b1);
        tick(); chk_if("st3", 16'h1004, 16'h0, 20'h3, 1'b1);

        // Redirect while in FETCH_IMM drops the held shl
        clear_mem();
        mem[5] = 16'hA000; mem[6] = 16'h1234; mem[40] = 16'h1111; mem[10] = 16'h2222;
        do_reset();
        redirect = 1'b1; redirect_pc = 20'd5;
        tick(); chk_if("rd0", 16'hF800, 16'h0, 20'h0, 1'b0);
        chk("rd0.addr", 32'(imem_addr), 32'd5);
        redirect = 1'b0;
        tick(); chk_if("rd1", 16'hF800, 16'h0, 20'h0, 1'b0);
        chk("rd1.addr", 32'(imem_addr), 32'd6);
        redirect = 1'b1; redirect_pc = 20'd40;
        tick(); chk_if("rd2", 16'hF800, 16'h0, 20'h0, 1'b0);
        chk("rd2.addr", 32'(imem_addr), 32'd40);
        redirect = 1'b0;
        tick(); chk_if("rd3", 16'h1111, 16'h0, 20'd40, 1'b1);

        // Redirect beats stall
        stall = 1'b1; redirect = 1'b1; redirect_pc = 20'd10;
        tick(); chk_if("rs0", 16'hF800, 16'h0, 20'h0, 1'b0);
        chk("rs0.addr", 32'(imem_addr), 32'd10);
        stall = 1'b0; redirect = 1'b0;
        tick(); chk_if("rs1", 16'h2222, 16'h0, 20'd10, 1'b1);

        // PC wrap between opcode and immediate
        top_word = 16'h3800; mem[0] = 16'h00CD;
        redirect = 1'b1; redirect_pc = 20'hFFFFF;
        tick(); chk("wr0.addr", 32'(imem_addr), 32'hFFFFF);
        redirect = 1'b0;
        tick(); chk_if("wr1", 16'hF800, 16'h0, 20'h0, 1'b0);
        chk("wr1.addr", 32'(imem_addr), 32'h0);
        tick(); chk_if("wr2", 16'h3800, 16'h00CD, 20'hFFFFF, 1'b1);
        chk("wr2.addr", 32'(imem_addr), 32'h1);

        // Async reset mid-cycle while in FETCH_IMM; partial shl never issues
        redirect = 1'b1; redirect_pc = 20'd5;
        tick();
        redirect = 1'b0;
        tick(); chk("ar.addr", 32'(imem_addr), 32'd6);
        #2 rst = 1'b1;
        #1;
        chk_if("async", 16'hF800, 16'h0, 20'h0, 1'b0);
        chk("async.addr", 32'(imem_addr), 32'h0);
        tick();
        rst = 1'b0;
        tick(); chk_if("ar1", 16'h00CD, 16'h0, 20'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
